// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding and default tuning constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } arb_state_e;

    localparam int DEF_MAX_D_STREAK = 2;
    localparam int DEF_TIMEOUT      = 255;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, with
// MEM priority, an IF anti-starvation streak limit and an access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    // Counter holds (busy cycles - 1), so the last allowed cycle is TIMEOUT-1.
    localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT - 1);

    arb_state_e        state_q,     state_d;
    logic [SW-1:0]     streak_q,    streak_d;
    logic [7:0]        to_cnt_q,    to_cnt_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-3:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q,   if_done_d;
    logic              d_done_q,    d_done_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              err_q,       err_d;

    logic grant_d;
    logic grant_i;
    logic timeout_hit;

    // Byte-lane bits are dropped: the memory is word addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    assign grant_d     = d_req && (!if_req || (streak_q < STREAK_MAX));
    assign grant_i     = !grant_d && if_req;
    assign timeout_hit = (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            to_cnt_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            to_cnt_q    <= to_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        to_cnt_d = to_cnt_q;
        unique case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (grant_d) begin
                    state_d = BUSY_D;
                    if (streak_q < STREAK_MAX) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (grant_i) begin
                    state_d  = BUSY_I;
                    streak_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                to_cnt_d = to_cnt_q + 8'd1;
                if (mem_ack || timeout_hit) begin
                    state_d = (state_q == BUSY_I) ? DONE_I : DONE_D;
                end
            end
            DONE_I, DONE_D: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr[ADDR_W-1:2];
                    mem_wdata_d = d_wdata;
                end else if (grant_i) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr[ADDR_W-1:2];
                end
            end
            BUSY_I: begin
                // An ack in the final allowed cycle still counts as success.
                if (mem_ack) begin
                    if_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    mem_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                end else if (timeout_hit) begin
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences and randomized rounds against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TO   = 4;
    localparam int MAXD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_done, d_done, stall_if, stall_mem, mem_req, mem_we, err;
    logic [31:0] if_rdata, d_rdata, mem_wdata;
    logic [29:0] mem_addr;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        bit ir; bit dr; bit we;
        logic [31:0] ia; logic [31:0] da; logic [31:0] wd;
        int dly;   // ack in busy cycle dly+1; negative = never
    } stim_t;

    typedef struct {
        bit first_d; int n;
        logic [29:0] addr0; bit we0; logic [31:0] wd0; int busy0; int done0;
        logic [29:0] addr1; int done1;
        logic [31:0] if_rd; logic [31:0] d_rd; bit err;
    } exp_t;

    typedef struct {
        bit first_d; int n; bit hung; bit stall_ok; bit stable0; bit stable1;
        logic [29:0] addr0; bit we0; logic [31:0] wd0; int busy0; int done0;
        logic [29:0] addr1; int done1;
        logic [31:0] if_rd; logic [31:0] d_rd; bit err;
    } obs_t;

    typedef struct { stim_t s; exp_t e; } vec_t;

    typedef struct {
        logic [29:0] addr; logic we; logic [31:0] wd; int len; bit stable;
    } grant_t;

    // External memory seen by the DUT, and the model's own view of it.
    logic [31:0] ext_mem [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    grant_t      glog[$];
    int          ack_delay = -1;

    int          ref_streak = 0;
    logic [31:0] ref_if_rd = '0;
    logic [31:0] ref_d_rd  = '0;
    bit          ref_err   = 1'b0;

    function automatic logic [31:0] pat(input logic [29:0] w);
        return {w[15:0] ^ 16'h5A5A, ~w[15:0]};
    endfunction

    function automatic logic [31:0] ext_rd(input logic [29:0] w);
        return ext_mem.exists(w) ? ext_mem[w] : pat(w);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : pat(w);
    endfunction

    // Memory responder: acks after ack_delay busy cycles, logs every grant.
    bit          in_busy = 1'b0;
    int          busy_cnt = 0;
    grant_t      cur;
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (!in_busy) begin
                in_busy    = 1'b1;
                busy_cnt   = 0;
                cur.addr   = mem_addr;
                cur.we     = mem_we;
                cur.wd     = mem_wdata;
                cur.stable = 1'b1;
            end else begin
                busy_cnt++;
                if (mem_addr !== cur.addr || mem_we !== cur.we || mem_wdata !== cur.wd)
                    cur.stable = 1'b0;
            end
            mem_ack = (ack_delay >= 0) && (busy_cnt == ack_delay);
            if (mem_ack) begin
                if (mem_we) ext_mem[mem_addr] = mem_wdata;
                mem_rdata = ext_rd(mem_addr);
            end else begin
                mem_rdata = $urandom;
            end
        end else begin
            if (in_busy) begin
                cur.len = busy_cnt + 1;
                glog.push_back(cur);
            end
            in_busy = 1'b0;
            mem_ack = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", tag, act, exp);
        end
    endtask

    // Transaction-level model: arbitration rule, latency and data outcome.
    function automatic exp_t predict(input stim_t s);
        exp_t e;
        bit to, is_d;
        int busy;
        logic [29:0] w;
        e = '{default: 0};
        if (s.dly < 0 || s.dly >= TO) begin busy = TO; to = 1'b1; end
        else begin busy = s.dly + 1; to = 1'b0; end
        e.first_d = s.dr && (!s.ir || ref_streak < MAXD);
        e.n = int'(s.ir) + int'(s.dr);
        for (int k = 0; k < e.n; k++) begin
            is_d = (k == 0) ? e.first_d : !e.first_d;
            w = is_d ? s.da[31:2] : s.ia[31:2];
            if (k == 0) begin
                e.addr0 = w; e.we0 = is_d && s.we; e.wd0 = s.wd;
                e.busy0 = busy; e.done0 = busy + 1;
            end else begin
                e.addr1 = w; e.done1 = e.done0 + 2 + busy;
            end
            ref_streak = is_d ? ((ref_streak < MAXD) ? ref_streak + 1 : MAXD) : 0;
            if (to)                ref_err = 1'b1;
            else if (is_d && s.we) ref_mem[w] = s.wd;
            else if (is_d)         ref_d_rd = ref_rd(w);
            else                   ref_if_rd = ref_rd(w);
        end
        e.if_rd = ref_if_rd; e.d_rd = ref_d_rd; e.err = ref_err;
        return e;
    endfunction

    task automatic record(inout obs_t o, input bit is_d, input int c);
        if (o.n == 0) begin o.first_d = is_d; o.done0 = c; end
        else o.done1 = c;
        o.n++;
    endtask

    task automatic run_round(input stim_t s, output obs_t o);
        int t0;
        bit need_i, need_d;
        o = '{default: 0};
        o.stall_ok = 1'b1;
        glog.delete();
        @(posedge clk); #1;
        ack_delay = s.dly;
        if_req = s.ir; if_addr = s.ia;
        d_req = s.dr; d_we = s.we; d_addr = s.da; d_wdata = s.wd;
        t0 = cyc;
        need_i = s.ir; need_d = s.dr;
        for (int k = 0; k < 60 && (need_i || need_d); k++) begin
            @(negedge clk);
            if (stall_if !== (if_req & ~if_done) || stall_mem !== (d_req & ~d_done))
                o.stall_ok = 1'b0;
            if (if_done) begin record(o, 1'b0, cyc - t0); if_req = 1'b0; need_i = 1'b0; end
            if (d_done)  begin record(o, 1'b1, cyc - t0); d_req = 1'b0;  need_d = 1'b0; end
        end
        o.hung  = need_i || need_d;
        o.if_rd = if_rdata; o.d_rd = d_rdata; o.err = err;
        if (glog.size() > 0) begin
            o.addr0 = glog[0].addr; o.we0 = glog[0].we; o.wd0 = glog[0].wd;
            o.busy0 = glog[0].len;  o.stable0 = glog[0].stable;
        end
        if (glog.size() > 1) begin
            o.addr1 = glog[1].addr; o.stable1 = glog[1].stable;
        end
    endtask

    task automatic check_round(input string nm, input obs_t o, input exp_t e);
        $display("round %s: dones=%0d first=%s addr0=%h busy0=%0d done0=%0d if_rdata=%h d_rdata=%h err=%0b",
                 nm, o.n, o.first_d ? "D" : "I", o.addr0, o.busy0, o.done0, o.if_rd, o.d_rd, o.err);
        chk({nm, ".hung"},   o.hung, 0);
        chk({nm, ".ndone"},  o.n, e.n);
        chk({nm, ".first"},  o.first_d, e.first_d);
        chk({nm, ".addr0"},  o.addr0, e.addr0);
        chk({nm, ".we0"},    o.we0, e.we0);
        if (e.we0) chk({nm, ".wdata0"}, o.wd0, e.wd0);
        chk({nm, ".busy0"},  o.busy0, e.busy0);
        chk({nm, ".done0"},  o.done0, e.done0);
        chk({nm, ".stable0"}, o.stable0, 1);
        if (e.n == 2) begin
            chk({nm, ".addr1"},   o.addr1, e.addr1);
            chk({nm, ".done1"},   o.done1, e.done1);
            chk({nm, ".stable1"}, o.stable1, 1);
        end
        chk({nm, ".if_rdata"}, o.if_rd, e.if_rd);
        chk({nm, ".d_rdata"},  o.d_rd, e.d_rd);
        chk({nm, ".err"},      o.err, e.err);
        chk({nm, ".stall"},    o.stall_ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tv[3];
        stim_t s;
        exp_t  e;
        obs_t  o;
        bit    ord[$];
        int    loads, code;
        bit    idone, bad;

        rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_ack = 0; mem_rdata = '0;
        ext_mem[30'h10] = 32'h8C22_0004; ref_mem[30'h10] = 32'h8C22_0004;
        ext_mem[30'h11] = 32'h0000_0013; ref_mem[30'h11] = 32'h0000_0013;
        ext_mem[30'h80] = 32'h1234_5678; ref_mem[30'h80] = 32'h1234_5678;

        tv[0].s = '{ir: 1, dr: 0, we: 0, ia: 32'h0000_0040, da: 32'h0, wd: 32'h0, dly: 0};
        tv[0].e = '{first_d: 0, n: 1, addr0: 30'h10, we0: 0, wd0: 32'h0, busy0: 1, done0: 2,
                    addr1: 30'h0, done1: 0, if_rd: 32'h8C22_0004, d_rd: 32'h0, err: 0};
        tv[1].s = '{ir: 0, dr: 1, we: 0, ia: 32'h0, da: 32'h0000_0200, wd: 32'h0, dly: 3};
        tv[1].e = '{first_d: 1, n: 1, addr0: 30'h80, we0: 0, wd0: 32'h0, busy0: 4, done0: 5,
                    addr1: 30'h0, done1: 0, if_rd: 32'h8C22_0004, d_rd: 32'h1234_5678, err: 0};
        tv[2].s = '{ir: 1, dr: 1, we: 1, ia: 32'h0000_0044, da: 32'h0000_0100, wd: 32'hDEAD_BEEF, dly: 0};
        tv[2].e = '{first_d: 1, n: 2, addr0: 30'h40, we0: 1, wd0: 32'hDEAD_BEEF, busy0: 1, done0: 2,
                    addr1: 30'h11, done1: 5, if_rd: 32'h0000_0013, d_rd: 32'h1234_5678, err: 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.mem_req", mem_req, 0);
        chk("reset.mem_we", mem_we, 0);
        chk("reset.mem_addr", mem_addr, 0);
        chk("reset.mem_wdata", mem_wdata, 0);
        chk("reset.if_done", if_done, 0);
        chk("reset.d_done", d_done, 0);
        chk("reset.if_rdata", if_rdata, 0);
        chk("reset.d_rdata", d_rdata, 0);
        chk("reset.err", err, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            e = predict(tv[i].s);   // keeps the model's state in step
            run_round(tv[i].s, o);
            check_round($sformatf("table%0d", i), o, tv[i].e);
        end

        // Starvation guard: IF held while three loads arrive back to back.
        @(posedge clk); #1;
        ack_delay = 0;
        if_req = 1; if_addr = 32'h0000_0100;
        d_req = 1; d_we = 0; d_addr = 32'h1000_0020;
        loads = 0; idone = 0;
        for (int k = 0; k < 80 && !(loads == 3 && idone); k++) begin
            @(negedge clk);
            if (d_done) begin
                ord.push_back(1'b1); loads++;
                if (loads == 3) d_req = 0; else d_addr = d_addr + 32'd4;
            end
            if (if_done) begin ord.push_back(1'b0); if_req = 0; idone = 1; end
        end
        code = 0;
        foreach (ord[i]) code = code * 2 + int'(ord[i]);
        $display("round starve: grants=%0d order_code=%b d_rdata=%h", ord.size(), code[3:0], d_rdata);
        chk("starve.count", ord.size(), 4);
        chk("starve.order_DDID", code, 13);
        chk("starve.d_rdata", d_rdata, ref_rd(30'h0400_000A));
        chk("starve.if_rdata", if_rdata, ref_rd(30'h40));
        ref_streak = 1; ref_d_rd = ref_rd(30'h0400_000A); ref_if_rd = ref_rd(30'h40);

        // Timeout: ack never comes; the following fetch must still be serviced.
        s = '{ir: 0, dr: 1, we: 0, ia: 32'h0, da: 32'h1000_0030, wd: 32'h0, dly: -1};
        e = predict(s);
        run_round(s, o);
        check_round("timeout", o, e);
        s = '{ir: 1, dr: 0, we: 0, ia: 32'h0000_0104, da: 32'h0, wd: 32'h0, dly: 1};
        e = predict(s);
        run_round(s, o);
        check_round("after_timeout", o, e);

        // Reset landing in BUSY_I.
        @(posedge clk); #1;
        ack_delay = -1; if_req = 1; if_addr = 32'h0000_0200;
        @(posedge clk); @(posedge clk); #2;
        chk("rst_mid.busy_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.mem_req", mem_req, 0);
        chk("rst_mid.err", err, 0);
        chk("rst_mid.if_rdata", if_rdata, 0);
        chk("rst_mid.mem_addr", mem_addr, 0);
        if_req = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (if_done || d_done || mem_req) bad = 1;
        end
        $display("round rst_mid: spurious_activity=%0b", bad);
        chk("rst_mid.no_done", bad, 0);
        ref_streak = 0; ref_if_rd = '0; ref_d_rd = '0; ref_err = 1'b0;
        s = '{ir: 1, dr: 0, we: 0, ia: 32'h0000_0040, da: 32'h0, wd: 32'h0, dly: 0};
        e = predict(s);
        run_round(s, o);
        check_round("post_reset", o, e);

        // Randomized rounds against the model.
        for (int r = 0; r < 40; r++) begin
            s.ir = 1'($urandom_range(0, 1));
            s.dr = 1'($urandom_range(0, 1));
            if (!s.ir && !s.dr) s.dr = 1'b1;
            s.we = 1'($urandom_range(0, 1));
            s.ia = {4'h0, 28'($urandom)};
            s.da = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            s.wd = $urandom;
            if ($urandom_range(0, 9) == 0) s.dly = -1;
            else s.dly = int'($urandom_range(0, 3));
            e = predict(s);
            run_round(s, o);
            check_round($sformatf("rand%0d", r), o, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the five-stage pipeline.
- Grants one requester at a time and drives a req/ack memory handshake.
- Returns read data to the requester and generates per-stage stall signals for the hazard logic.
- MEM wins ties, because it holds the older instruction. A streak counter stops IF from starving.

Parameters:
- ADDR_W, 32, byte-address width of both requester addresses.
- DATA_W, 32, memory data width.
- MAX_D_STREAK, 2, number of consecutive data grants allowed while if_req is pending; the next grant then goes to IF.
- TIMEOUT, 255, cycles to wait for mem_ack before abandoning the access. Range 1..255, held in an 8-bit counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level; held until if_done.
- if_addr  in  ADDR_W  fetch byte address.
- if_done  out  1  one-cycle pulse; if_rdata valid in this cycle.
- if_rdata  out  DATA_W  fetched instruction, registered.
- d_req  in  1  data request, level; held until d_done.
- d_we  in  1  1 = store (sw), 0 = load (lw); from the decoder memwrite.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle pulse; d_rdata valid in this cycle for loads.
- d_rdata  out  DATA_W  load data, registered.
- stall_if  out  1  if_req & ~if_done.
- stall_mem  out  1  d_req & ~d_done.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W-2  word address, taken from addr[ADDR_W-1:2].
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  access complete; sampled only while mem_req = 1.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - FSM goes to IDLE.
  - mem_req, mem_we, if_done, d_done and err are all 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata, the streak counter and the timeout counter are all 0.
  - If reset lands mid-access, mem_req drops immediately. The memory must tolerate an abandoned request.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE:
  - Evaluates requests every cycle.
  - d_req=1 with (if_req=0 or streak<MAX_D_STREAK): go to BUSY_D. Latch d_we/d_addr/d_wdata into mem_*, set mem_req=1, increment streak, saturating.
  - Otherwise if_req=1: go to BUSY_I. Latch if_addr, set mem_we=0 and mem_req=1, clear streak to 0.
  - Neither request: stay in IDLE, outputs unchanged, mem_req=0.
- BUSY_x:
  - mem_* are held stable. The timeout counter increments each cycle.
  - mem_ack=1: capture mem_rdata into if_rdata (BUSY_I) or into d_rdata when the access is a load (BUSY_D). Stores leave d_rdata unchanged. Then mem_req<=0, go to DONE_x.
  - Counter reaches TIMEOUT with no ack: err<=1, mem_req<=0, go to DONE_x. Read data is undefined; the last registered value is kept.
- DONE_x:
  - x_done=1 for exactly one cycle, then back to IDLE. No new grant is made in this cycle.
  - The requester must drop its request or present a new one in the DONE cycle. A request still high in IDLE is treated as new.
- Latency:
  - Zero-wait memory (ack in the first BUSY cycle): req rises at cycle 0, grant at edge 1, done pulse at cycle 2, next grant earliest at edge 4.
  - Each extra wait cycle adds one.
- Streak counter: cleared only by an IF grant. A data grant made while if_req=0 still increments it, saturating at MAX_D_STREAK.
- stall_if and stall_mem are combinational from the inputs and the registered done pulses. There is no reset dependence beyond the done registers.
- err clears only on reset.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE=0, BUSY_I=1, BUSY_D=2, DONE_I=3, DONE_D=4, 3 bits);
  - the default constants for MAX_D_STREAK and TIMEOUT.
- No sub-module. The FSM and both counters live in one module of roughly 200 lines.

Test Plan:
- IF only, zero-wait memory:
  - Stimulus: if_addr=0x0000_0040, mem_rdata=0x8C22_0004 with ack in the first BUSY cycle.
  - Required: mem_addr=0x10, mem_we=0; if_done pulses at cycle 2 with if_rdata=0x8C22_0004; stall_if=1 in cycles 0..1.
- Simultaneous if_req and d_req:
  - Stimulus: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF.
  - Required: the data access goes first (mem_we=1, mem_addr=0x40); d_done pulses, then IF is granted; d_rdata is unchanged.
- Starvation guard:
  - Stimulus: if_req held high with three back-to-back loads, MAX_D_STREAK=2.
  - Required: grant order is D, D, I, D.
- Wait states:
  - Stimulus: load with ack 3 cycles late, mem_rdata=0x1234_5678.
  - Required: mem_* stable throughout; d_done at cycle 5; d_rdata=0x1234_5678.
- Timeout:
  - Stimulus: TIMEOUT=4 and mem_ack never asserted.
  - Required: mem_req drops after 4 BUSY cycles; err=1 and stays 1; d_done pulses; the next request is still serviced.
- Reset mid-access:
  - Stimulus: rst_n=0 during BUSY_I.
  - Required: mem_req=0 with no clock edge; state IDLE; no if_done pulse after release.
